// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler plus per-channel OFF/ON/BLINK/BURST engines.
// Optional build macro LED_PWM_DIM_EN adds a per-channel 4-bit duty setting for ON-phase dimming.
`timescale 1ns/1ps

module led_pattern_gen #(
  parameter int CLK_HZ   = 12000000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_CH   = 5,
  parameter int PER_W    = 16,
  parameter int BURST_W  = 4,
  parameter int RST_HALF = 500
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                  cfg_mode,
  input  logic [PER_W-1:0]                            cfg_half,
  input  logic [BURST_W-1:0]                          cfg_cnt,
`ifdef LED_PWM_DIM_EN
  input  logic [3:0]                                  cfg_duty,
`endif
  output logic                                        tick,
  output logic [NUM_CH-1:0]                           led
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW   = PER_W + 2;  // wide enough for the 4*Hm gap count

  typedef enum logic [1:0] {
    M_OFF   = 2'b00,
    M_ON    = 2'b01,
    M_BLINK = 2'b10,
    M_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    B_ON  = 2'd0,
    B_OFF = 2'd1,
    B_GAP = 2'd2
  } bst_e;

  if (DIV < 2) begin : g_div_check
    $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_check
    $error("led_pattern_gen: NUM_CH must be in 1..16");
  end

  logic [PS_W-1:0] pre_cnt;
  logic            wrap;

  assign wrap = (pre_cnt == PS_W'(DIV - 1));
  assign tick = wrap;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt <= '0;
    else        pre_cnt <= wrap ? '0 : pre_cnt + PS_W'(1);
  end

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e              mode_q, mode_d;
    bst_e               bst_q, bst_d;
    logic [PER_W-1:0]   half_q, half_d, hm;
    logic [BURST_W-1:0] cnt_q, cnt_d, pulse_q, pulse_d;
    logic [CW-1:0]      ctr_q, ctr_d, ctr_inc;
    logic               lvl_q, lvl_d, led_q, led_d, on_d;
    logic               wr, ph_last, gap_last;
`ifdef LED_PWM_DIM_EN
    logic [3:0]         duty_q, duty_d;
`endif

    // Out-of-range channel numbers match no channel, so such writes are dropped.
    assign wr       = cfg_we && (cfg_ch == CH_W'(i));
    assign hm       = (half_q == '0) ? PER_W'(1) : half_q;
    assign ph_last  = (ctr_q == CW'(hm) - CW'(1));
    assign gap_last = (ctr_q == {hm, 2'b00} - CW'(1));
    assign ctr_inc  = ctr_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q  <= (i == 0) ? M_BLINK : M_OFF;
        half_q  <= (i == 0) ? PER_W'(RST_HALF) : '0;
        cnt_q   <= '0;
        pulse_q <= '0;
        ctr_q   <= '0;
        bst_q   <= B_ON;
        lvl_q   <= 1'b1;
        led_q   <= (i == 0);
`ifdef LED_PWM_DIM_EN
        duty_q  <= 4'd15;
`endif
      end else begin
        mode_q  <= mode_d;
        half_q  <= half_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
        ctr_q   <= ctr_d;
        bst_q   <= bst_d;
        lvl_q   <= lvl_d;
        led_q   <= led_d;
`ifdef LED_PWM_DIM_EN
        duty_q  <= duty_d;
`endif
      end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
      mode_d  = mode_q;
      half_d  = half_q;
      cnt_d   = cnt_q;
      pulse_d = pulse_q;
      ctr_d   = ctr_q;
      bst_d   = bst_q;
      lvl_d   = lvl_q;
`ifdef LED_PWM_DIM_EN
      duty_d  = duty_q;
`endif
      if (wr) begin
        // A write takes precedence over a tick arriving in the same cycle.
        mode_d  = mode_e'(cfg_mode);
        half_d  = cfg_half;
        cnt_d   = cfg_cnt;
        pulse_d = '0;
        ctr_d   = '0;
        bst_d   = B_ON;
        lvl_d   = 1'b1;
`ifdef LED_PWM_DIM_EN
        duty_d  = cfg_duty;
`endif
      end else if (tick) begin
        case (mode_q)
          M_BLINK: begin
            ctr_d = ph_last ? '0 : ctr_inc;
            if (ph_last) lvl_d = ~lvl_q;
          end
          M_BURST: begin
            case (bst_q)
              B_ON: begin
                ctr_d = ph_last ? '0 : ctr_inc;
                if (ph_last) begin
                  bst_d   = B_OFF;
                  pulse_d = pulse_q + BURST_W'(1);
                end
              end
              B_OFF: begin
                ctr_d = ph_last ? '0 : ctr_inc;
                if (ph_last) bst_d = (pulse_q < cnt_q) ? B_ON : B_GAP;
              end
              default: begin
                ctr_d = gap_last ? '0 : ctr_inc;
                if (gap_last) begin
                  bst_d   = B_ON;
                  pulse_d = '0;
                end
              end
            endcase
          end
          default: ;
        endcase
      end

      case (mode_d)
        M_ON:    on_d = 1'b1;
        M_BLINK: on_d = lvl_d;
        M_BURST: on_d = (bst_d == B_ON) && (cnt_d != '0);
        default: on_d = 1'b0;
      endcase
`ifdef LED_PWM_DIM_EN
      led_d = on_d && (pwm_cnt <= duty_d);
`else
      led_d = on_d;
`endif
    end

    assign led[i] = led_q;
  end

endmodule
